// File: rtl/multicycle_control.sv
// Multicycle LEGv8-style control unit: fetch/decode/execute sequencing,
// memory-wait timeout supervision, retire counting and sticky fault capture.
//
// Memory handshake: the controller holds MemRead or MemWrite high for the
// whole memory state; a transfer completes in the cycle mem_ready=1 is seen
// while the strobe is high. Nothing is latched from a cycle with mem_ready=0.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] Opcode,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IRWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        Reg2Loc,
   output logic        ALUSrcA,
   output logic        PCSource,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic [3:0]  state,
   output logic        instr_done,
   output logic [15:0] retired,
   output logic [1:0]  fault_code
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC_R = 4'd2;
   localparam logic [3:0] S_WB_R   = 4'd3;
   localparam logic [3:0] S_ADDR   = 4'd4;
   localparam logic [3:0] S_MEM_RD = 4'd5;
   localparam logic [3:0] S_WB_LD  = 4'd6;
   localparam logic [3:0] S_MEM_WR = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_HALT   = 4'd15;

   localparam logic [1:0] F_NONE    = 2'b00;
   localparam logic [1:0] F_ILLEGAL = 2'b01;
   localparam logic [1:0] F_TIMEOUT = 2'b10;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ_PREFIX = 8'b10110100;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

   logic [3:0]  r_state;
   logic [3:0]  w_next_state;
   logic [1:0]  w_next_fault;
   logic [7:0]  r_wait_cnt;
   logic [15:0] r_retired;
   logic [1:0]  r_fault;

   logic w_is_rtype;
   logic w_is_ldur;
   logic w_is_stur;
   logic w_is_cbz;
   logic w_mem_state;
   logic w_timeout;

   assign w_is_rtype = (Opcode == OP_ADD) || (Opcode == OP_SUB) ||
                       (Opcode == OP_AND) || (Opcode == OP_ORR);
   assign w_is_ldur  = (Opcode == OP_LDUR);
   assign w_is_stur  = (Opcode == OP_STUR);
   assign w_is_cbz   = (Opcode[10:3] == OP_CBZ_PREFIX);

   // States in which the wait counter runs and the timeout is armed.
   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
   // Counter has already sat MEM_TIMEOUT cycles and memory is still not ready.
   assign w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == TIMEOUT_LIMIT);

   assign state      = r_state;
   assign retired    = r_retired;
   assign fault_code = r_fault;

   // Second register operand comes from Rt for stores and CBZ.
   assign Reg2Loc = (r_state != S_FETCH) && (r_state != S_HALT) && (w_is_stur || w_is_cbz);

   // Next-state selection and the fault cause reported if the next state is HALT.
   always_comb begin
      w_next_state = r_state;
      w_next_fault = F_NONE;
      case (r_state)
         S_FETCH: begin
            if (mem_ready) begin
               w_next_state = S_DECODE;
            end else if (w_timeout) begin
               w_next_state = S_HALT;
               w_next_fault = F_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (w_is_rtype) begin
               w_next_state = S_EXEC_R;
            end else if (w_is_ldur || w_is_stur) begin
               w_next_state = S_ADDR;
            end else if (w_is_cbz) begin
               w_next_state = S_BRANCH;
            end else begin
               w_next_state = S_HALT;
               w_next_fault = F_ILLEGAL;
            end
         end
         S_EXEC_R: w_next_state = S_WB_R;
         S_WB_R:   w_next_state = S_FETCH;
         S_ADDR: begin
            // Opcode is stable after DECODE; anything else here is treated as illegal.
            if (w_is_ldur) begin
               w_next_state = S_MEM_RD;
            end else if (w_is_stur) begin
               w_next_state = S_MEM_WR;
            end else begin
               w_next_state = S_HALT;
               w_next_fault = F_ILLEGAL;
            end
         end
         S_MEM_RD: begin
            if (mem_ready) begin
               w_next_state = S_WB_LD;
            end else if (w_timeout) begin
               w_next_state = S_HALT;
               w_next_fault = F_TIMEOUT;
            end
         end
         S_WB_LD: w_next_state = S_FETCH;
         S_MEM_WR: begin
            if (mem_ready) begin
               w_next_state = S_FETCH;
            end else if (w_timeout) begin
               w_next_state = S_HALT;
               w_next_fault = F_TIMEOUT;
            end
         end
         S_BRANCH: w_next_state = S_FETCH;
         S_HALT:   w_next_state = S_HALT;
         default: begin
            // Unused encodings are unreachable; park safely if ever entered.
            w_next_state = S_HALT;
            w_next_fault = F_ILLEGAL;
         end
      endcase
   end

   // Datapath strobes and mux selects decoded from the current state.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      PCSource    = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      instr_done  = 1'b0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_WB_R: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
         end
         S_WB_LD: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WR: begin
            MemWrite   = 1'b1;
            instr_done = mem_ready;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 1'b1;
            instr_done  = 1'b1;
         end
         default: begin
            // HALT and unused encodings keep every strobe low.
         end
      endcase
   end

   // State register; reset overrides every transition and memory response.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Wait counter restarts on every state change and counts not-ready cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt <= 8'd0;
      end else if (w_next_state != r_state) begin
         r_wait_cnt <= 8'd0;
      end else if (w_mem_state && !mem_ready) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // Retired-instruction counter, wrapping naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retired <= 16'd0;
      end else if (instr_done) begin
         r_retired <= r_retired + 16'd1;
      end
   end

   // Fault cause captured once on entry to HALT and held until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fault <= F_NONE;
      end else if ((r_state != S_HALT) && (w_next_state == S_HALT)) begin
         r_fault <= w_next_fault;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each instruction is expanded into
// the cycle-by-cycle state walk it must take, and every cycle is compared.
module tb_multicycle_control;

   localparam int MEM_TO = 15;

   localparam logic [3:0] ST_FETCH  = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [3:0] ST_EXEC_R = 4'd2;
   localparam logic [3:0] ST_WB_R   = 4'd3;
   localparam logic [3:0] ST_ADDR   = 4'd4;
   localparam logic [3:0] ST_MEM_RD = 4'd5;
   localparam logic [3:0] ST_WB_LD  = 4'd6;
   localparam logic [3:0] ST_MEM_WR = 4'd7;
   localparam logic [3:0] ST_BRANCH = 4'd8;
   localparam logic [3:0] ST_HALT   = 4'd15;

   localparam logic [10:0] ADD  = 11'b10001011000;
   localparam logic [10:0] SUB  = 11'b11001011000;
   localparam logic [10:0] ANDI = 11'b10001010000;
   localparam logic [10:0] ORR  = 11'b10101010000;
   localparam logic [10:0] LDUR = 11'b11111000010;
   localparam logic [10:0] STUR = 11'b11111000000;
   localparam logic [10:0] CBZ  = 11'b10110100101;
   localparam logic [10:0] CBZ2 = 11'b10110100000;
   localparam logic [10:0] BAD  = 11'b00000000000;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] Opcode;
   logic        mem_ready;
   logic        PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, MemtoReg;
   logic        RegWrite, Reg2Loc, ALUSrcA, PCSource, instr_done;
   logic [1:0]  ALUSrcB, ALUOp, fault_code;
   logic [3:0]  state;
   logic [15:0] retired;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(MEM_TO)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA),
      .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .state(state), .instr_done(instr_done), .retired(retired),
      .fault_code(fault_code)
   );

   logic [14:0] w_ctrl;
   assign w_ctrl = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, MemtoReg,
                    RegWrite, Reg2Loc, ALUSrcA, PCSource, ALUSrcB, ALUOp, instr_done};

   // ---------------- scoreboard ----------------
   typedef struct {
      int          idx;
      logic [3:0]  st;
      logic [14:0] ctrl;
      logic [15:0] ret;
      logic [1:0]  flt;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_push = 0;

   logic [15:0] m_retired;
   logic [1:0]  m_fault;
   int          m_cycles;
   bit          m_halted;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (vec %0d): got %0h, want %0h", nm, idx, act, exp);
      end
   endtask

   // Control word the table of per-state actions demands, packed like w_ctrl.
   function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic [10:0] op);
      logic pcw, pcwc, irw, mrd, mwr, m2r, rw, r2l, asa, pcs, done;
      logic [1:0] asb, aop;
      pcw = 0; pcwc = 0; irw = 0; mrd = 0; mwr = 0; m2r = 0; rw = 0;
      asa = 0; pcs = 0; done = 0; asb = 2'b00; aop = 2'b00;
      r2l = (st != ST_FETCH) && (st != ST_HALT) && ((op == STUR) || (op[10:3] == 8'b10110100));
      case (st)
         ST_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
         ST_DECODE: begin asb = 2'b11; end
         ST_EXEC_R: begin asa = 1; aop = 2'b10; end
         ST_WB_R:   begin rw = 1; done = 1; end
         ST_ADDR:   begin asa = 1; asb = 2'b10; end
         ST_MEM_RD: begin mrd = 1; end
         ST_WB_LD:  begin rw = 1; m2r = 1; done = 1; end
         ST_MEM_WR: begin mwr = 1; done = mr; end
         ST_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 1; done = 1; end
         default:   begin end
      endcase
      return {pcw, pcwc, irw, mrd, mwr, m2r, rw, r2l, asa, pcs, asb, aop, done};
   endfunction

   function automatic logic rbit();
      return ($urandom_range(0, 1) != 0);
   endfunction

   // Single compare process: one expected record per driven cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         chk("state",      cur.idx, {28'd0, state},      {28'd0, cur.st});
         chk("ctrl",       cur.idx, {17'd0, w_ctrl},     {17'd0, cur.ctrl});
         chk("retired",    cur.idx, {16'd0, retired},    {16'd0, cur.ret});
         chk("fault_code", cur.idx, {30'd0, fault_code}, {30'd0, cur.flt});
      end
   end

   // ---------------- driver tasks ----------------
   // Drive one cycle (called #1 after a rising edge) and record what it must show.
   task automatic step(input logic [10:0] op, input logic mr, input logic [3:0] st, input logic rst);
      exp_t        e;
      logic [14:0] c;
      Opcode    = op;
      mem_ready = mr;
      reset     = rst;
      c         = exp_ctrl(st, mr, op);
      e.idx  = n_push;
      e.st   = st;
      e.ctrl = c;
      e.ret  = m_retired;
      e.flt  = m_fault;
      exp_q.push_back(e);
      n_push++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      if (rst) begin
         m_retired = 16'd0;
         m_fault   = 2'b00;
      end else if (c[0]) begin
         m_retired = m_retired + 16'd1;
      end
   endtask

   // A memory state: nwait not-ready cycles, then completion unless the limit trips.
   task automatic mem_phase(input logic [10:0] op, input logic [3:0] st, input int nwait);
      for (int i = 0; i < nwait; i++) begin
         step(op, 1'b0, st, 1'b0);
         m_cycles++;
         if (i == MEM_TO) begin
            m_fault  = 2'b10;
            m_halted = 1'b1;
            return;
         end
      end
      step(op, 1'b1, st, 1'b0);
      m_cycles++;
   endtask

   // Whole instruction from FETCH, expanded by instruction class.
   task automatic run_instr(input logic [10:0] op, input int fw, input int mw);
      m_cycles = 0;
      m_halted = 1'b0;
      mem_phase(op, ST_FETCH, fw);
      if (!m_halted) begin
         step(op, rbit(), ST_DECODE, 1'b0);
         m_cycles++;
         if (op == ADD || op == SUB || op == ANDI || op == ORR) begin
            step(op, rbit(), ST_EXEC_R, 1'b0);
            step(op, rbit(), ST_WB_R, 1'b0);
            m_cycles += 2;
         end else if (op == LDUR) begin
            step(op, rbit(), ST_ADDR, 1'b0);
            m_cycles++;
            mem_phase(op, ST_MEM_RD, mw);
            if (!m_halted) begin
               step(op, rbit(), ST_WB_LD, 1'b0);
               m_cycles++;
            end
         end else if (op == STUR) begin
            step(op, rbit(), ST_ADDR, 1'b0);
            m_cycles++;
            mem_phase(op, ST_MEM_WR, mw);
         end else if (op[10:3] == 8'b10110100) begin
            step(op, rbit(), ST_BRANCH, 1'b0);
            m_cycles++;
         end else begin
            m_fault  = 2'b01;
            m_halted = 1'b1;
         end
      end
      if (m_halted) begin
         for (int k = 0; k < 3; k++) step(op, rbit(), ST_HALT, 1'b0);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset     = 1'b1;
      Opcode    = 11'd0;
      mem_ready = 1'b0;
      m_retired = 16'd0;
      m_fault   = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_state",   -1, {28'd0, state},      32'd0);
      chk("reset_retired", -1, {16'd0, retired},    32'd0);
      chk("reset_fault",   -1, {30'd0, fault_code}, 32'd0);
      chk("reset_done",    -1, {31'd0, instr_done}, 32'd0);

      run_instr(ADD, 0, 0);
      chk("add_latency", -1, m_cycles, 32'd4);
      chk("add_retired", -1, {16'd0, retired}, 32'd1);
      run_instr(SUB, 0, 0);
      run_instr(ANDI, 2, 0);
      chk("and_latency_fetch_wait", -1, m_cycles, 32'd6);
      run_instr(ORR, 0, 0);
      run_instr(LDUR, 0, 3);
      chk("ldur_wait_latency", -1, m_cycles, 32'd8);
      run_instr(LDUR, 0, 0);
      chk("ldur_latency", -1, m_cycles, 32'd5);
      run_instr(STUR, 0, 0);
      chk("stur_latency", -1, m_cycles, 32'd4);
      run_instr(STUR, 1, 2);
      run_instr(CBZ, 0, 0);
      chk("cbz_latency", -1, m_cycles, 32'd3);
      chk("retired_count", -1, {16'd0, retired}, 32'd9);
      run_instr(CBZ2, 0, 0);

      // Illegal opcode: HALT with fault 01, strobes low until reset.
      run_instr(BAD, 0, 0);
      chk("illegal_state", -1, {28'd0, state},      32'd15);
      chk("illegal_fault", -1, {30'd0, fault_code}, 32'd1);
      chk("illegal_ctrl",  -1, {17'd0, w_ctrl},     32'd0);
      step(BAD, 1'b1, ST_HALT, 1'b1);
      chk("halt_reset_state",   -1, {28'd0, state},   32'd0);
      chk("halt_reset_retired", -1, {16'd0, retired}, 32'd0);

      // Fetch timeout: 16th not-ready cycle trips the limit.
      run_instr(ADD, 16, 0);
      chk("timeout_state", -1, {28'd0, state},      32'd15);
      chk("timeout_fault", -1, {30'd0, fault_code}, 32'd2);
      step(ADD, 1'b0, ST_HALT, 1'b1);

      // Ready arriving in the cycle the counter equals the limit completes normally.
      run_instr(ADD, 15, 0);
      chk("edge_ready_fault",   -1, {30'd0, fault_code}, 32'd0);
      chk("edge_ready_latency", -1, m_cycles, 32'd19);
      chk("edge_ready_retired", -1, {16'd0, retired}, 32'd1);

      // Reset in MEM_WR beats the concurrent mem_ready completion.
      step(STUR, 1'b1, ST_FETCH, 1'b0);
      step(STUR, 1'b1, ST_DECODE, 1'b0);
      step(STUR, 1'b0, ST_ADDR, 1'b0);
      step(STUR, 1'b0, ST_MEM_WR, 1'b0);
      step(STUR, 1'b0, ST_MEM_WR, 1'b0);
      step(STUR, 1'b1, ST_MEM_WR, 1'b1);
      chk("memwr_reset_state",    -1, {28'd0, state},    32'd0);
      chk("memwr_reset_memwrite", -1, {31'd0, MemWrite}, 32'd0);
      chk("memwr_reset_retired",  -1, {16'd0, retired},  32'd0);
      run_instr(ADD, 1, 0);

      // Retire counter wrap from 0xFFFF.
      step(ADD, 1'b0, ST_FETCH, 1'b1);
      dut.r_retired = 16'hFFFF;
      m_retired     = 16'hFFFF;
      run_instr(CBZ, 0, 0);
      chk("retired_wrap", -1, {16'd0, retired}, 32'd0);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
